// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter.
// Holds the FSM state encoding and the index-width helper used by the top and the picker.
package obi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // Width needed to index n requesters; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_arbiter_rr_pick.sv
// Combinational round-robin picker: the lowest requesting index at or above the pointer wins,
// and the search wraps around to index 0 when nothing at or above the pointer is requesting.
module rr_pick
    import obi_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_src;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (IDX_W'(i) >= i_ptr);
        end
    end

    assign w_masked = i_req & w_mask;
    // The masked search has priority; the unmasked search handles the wrap-around.
    assign w_src    = (|w_masked) ? w_masked : i_req;
    assign o_valid  = |i_req;

    always_comb begin
        o_idx    = '0;
        o_onehot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_src[i]) begin
                o_idx = IDX_W'(i);
            end
        end
        if (o_valid) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/obi_arbiter.sv
// Round-robin arbiter sharing one OBI slave port between NUM_REQ masters,
// with a single transaction outstanding downstream.
//
// state    | meaning
// ARB_IDLE | no transaction; pick a winner from s_req_i and latch it as owner
// ARB_REQ  | m_req_o high with owner's fields; waiting for m_gnt_i
// ARB_RESP | granted; waiting for m_rvalid_i
module obi_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          s_req_i,
    output logic [NUM_REQ-1:0]          s_gnt_o,
    input  logic [NUM_REQ*ADDR_W-1:0]   s_addr_i,
    input  logic [NUM_REQ-1:0]          s_wr_en_i,
    input  logic [NUM_REQ*DATA_W/8-1:0] s_byte_en_i,
    input  logic [NUM_REQ*DATA_W-1:0]   s_wdata_i,
    output logic [NUM_REQ-1:0]          s_rvalid_o,
    output logic [NUM_REQ*DATA_W-1:0]   s_rdata_o,
    output logic                        m_req_o,
    input  logic                        m_gnt_i,
    output logic [ADDR_W-1:0]           m_addr_o,
    output logic                        m_wr_en_o,
    output logic [DATA_W/8-1:0]         m_byte_en_o,
    output logic [DATA_W-1:0]           m_wdata_o,
    input  logic                        m_rvalid_i,
    input  logic [DATA_W-1:0]           m_rdata_i
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int BE_W  = DATA_W / 8;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [NUM_REQ-1:0] r_owner_oh;
    logic [IDX_W-1:0]   r_prio_ptr;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic               w_in_req;
    logic               w_busy;
    logic               w_done;
    logic [IDX_W-1:0]   w_ptr_nxt;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (s_req_i),
        .i_ptr    (r_prio_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_pick_valid) w_state_nxt = ARB_REQ;
            ARB_REQ:  if (m_gnt_i)      w_state_nxt = m_rvalid_i ? ARB_IDLE : ARB_RESP;
            ARB_RESP: if (m_rvalid_i)   w_state_nxt = ARB_IDLE;
            default:                    w_state_nxt = ARB_IDLE;
        endcase
    end

    assign w_in_req  = (r_state == ARB_REQ);
    assign w_busy    = (r_state == ARB_REQ) || (r_state == ARB_RESP);
    assign w_done    = (w_in_req && m_gnt_i && m_rvalid_i) || ((r_state == ARB_RESP) && m_rvalid_i);
    assign w_ptr_nxt = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

    // Owner is kept both as an index (request mux) and one-hot (response demux).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner    <= '0;
            r_owner_oh <= NUM_REQ'(1);
            r_prio_ptr <= '0;
        end else begin
            if ((r_state == ARB_IDLE) && w_pick_valid) begin
                r_owner    <= w_pick_idx;
                r_owner_oh <= w_pick_onehot;
            end
            if (w_done) begin
                r_prio_ptr <= w_ptr_nxt;
            end
        end
    end

    always_comb begin
        m_req_o     = w_in_req;
        m_addr_o    = '0;
        m_wr_en_o   = 1'b0;
        m_byte_en_o = '0;
        m_wdata_o   = '0;
        if (w_in_req) begin
            m_addr_o    = s_addr_i[int'(r_owner)*ADDR_W +: ADDR_W];
            m_wr_en_o   = s_wr_en_i[r_owner];
            m_byte_en_o = s_byte_en_i[int'(r_owner)*BE_W +: BE_W];
            m_wdata_o   = s_wdata_i[int'(r_owner)*DATA_W +: DATA_W];
        end
    end

    assign s_gnt_o    = (w_in_req && m_gnt_i) ? r_owner_oh : '0;
    assign s_rvalid_o = (w_busy && m_rvalid_i) ? r_owner_oh : '0;

    always_comb begin
        s_rdata_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_busy && r_owner_oh[i]) begin
                s_rdata_o[i*DATA_W +: DATA_W] = m_rdata_i;
            end
        end
    end

endmodule
